// File: rtl/s2mm_pixel_packer.sv
// s2mm_pixel_packer: packs an AXI-Stream pixel stream into wide words with
// per-pixel keep, pads partial words at end of line, enforces frame sync and
// checks line length / frame height against img_width / img_height.
module s2mm_pixel_packer #(
  parameter int unsigned C_PIXEL_WIDTH     = 8,
  parameter int unsigned C_PIXELS_PER_BEAT = 4,
  parameter int unsigned C_IMG_WBITS       = 12,
  parameter int unsigned C_IMG_HBITS       = 12,
  parameter int unsigned C_RESYNC          = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [C_IMG_WBITS-1:0]                     img_width,
  input  logic [C_IMG_HBITS-1:0]                     img_height,
  input  logic                                       s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0]                   s_axis_tdata,
  input  logic                                       s_axis_tuser,
  input  logic                                       s_axis_tlast,
  output logic                                       s_axis_tready,
  output logic                                       m_axis_tvalid,
  output logic [C_PIXEL_WIDTH*C_PIXELS_PER_BEAT-1:0] m_axis_tdata,
  output logic [C_PIXELS_PER_BEAT-1:0]               m_axis_tkeep,
  output logic                                       m_axis_tuser,
  output logic                                       m_axis_tlast,
  input  logic                                       m_axis_tready,
  output logic                                       frame_done,
  output logic                                       line_err,
  output logic                                       sof_err
);

  localparam int unsigned PW = C_PIXEL_WIDTH;
  localparam int unsigned NP = C_PIXELS_PER_BEAT;
  localparam int unsigned DW = PW * NP;
  localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned WB = C_IMG_WBITS;
  localparam int unsigned HB = C_IMG_HBITS;

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_PACK = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (C_RESYNC != 0) ? ST_SYNC : ST_PACK;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   asm_data;
  logic [NP-1:0]   asm_keep;
  logic            asm_user;
  logic [WB-1:0]   pix_cnt;
  logic [HB-1:0]   line_cnt;

  logic            accept;
  logic            take;
  logic            mid_sof;
  logic [IW-1:0]   base_idx;
  logic [DW-1:0]   base_data;
  logic [NP-1:0]   base_keep;
  logic            base_user;
  logic [WB-1:0]   base_pix;
  logic [HB-1:0]   base_line;
  logic [DW-1:0]   word_data;
  logic [NP-1:0]   word_keep;
  logic            word_user;
  logic            word_done;
  logic [WB-1:0]   pix_next;
  logic [HB-1:0]   line_next;
  logic            len_bad;
  logic            frame_end;

  // Input handshake: SYNC always drains, PACK stalls only while a word is held and not taken
  always_comb begin
    s_axis_tready = 1'b1;
    if (state == ST_PACK) begin
      s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    end
  end

  // Per-pixel datapath: an SOF pixel restarts the word and counters before it is placed
  always_comb begin
    accept    = s_axis_tvalid & s_axis_tready;
    take      = accept & ((state == ST_PACK) | s_axis_tuser);
    mid_sof   = (state == ST_PACK) & s_axis_tuser &
                ((idx != '0) | (line_cnt != '0) | (pix_cnt != '0));
    base_idx  = s_axis_tuser ? '0 : idx;
    base_data = s_axis_tuser ? '0 : asm_data;
    base_keep = s_axis_tuser ? '0 : asm_keep;
    base_user = s_axis_tuser ? 1'b0 : asm_user;
    base_pix  = s_axis_tuser ? '0 : pix_cnt;
    base_line = s_axis_tuser ? '0 : line_cnt;
    word_data = base_data;
    word_keep = base_keep;
    for (int i = 0; i < NP; i++) begin
      if (IW'(i) == base_idx) begin
        word_data[i*PW +: PW] = s_axis_tdata;
        word_keep[i]          = 1'b1;
      end
    end
    word_user = base_user | s_axis_tuser;
    word_done = (base_idx == IW'(NP - 1)) | s_axis_tlast;
    pix_next  = WB'(base_pix + WB'(1));
    line_next = HB'(base_line + HB'(1));
    len_bad   = (img_width != '0) & (pix_next != img_width);
    frame_end = s_axis_tlast & (img_height != '0) & (line_next == img_height);
  end

  // State, assembly register, counters, output word and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RESET_STATE;
      idx           <= '0;
      asm_data      <= '0;
      asm_keep      <= '0;
      asm_user      <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_done    <= 1'b0;
      line_err      <= 1'b0;
      sof_err       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      sof_err    <= 1'b0;
      if (m_axis_tvalid & m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (take) begin
        sof_err <= mid_sof;
        state   <= ST_PACK;
        if (word_done) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= word_data;
          m_axis_tkeep  <= word_keep;
          m_axis_tuser  <= word_user;
          m_axis_tlast  <= s_axis_tlast;
          idx           <= '0;
          asm_data      <= '0;
          asm_keep      <= '0;
          asm_user      <= 1'b0;
        end else begin
          idx      <= IW'(base_idx + IW'(1));
          asm_data <= word_data;
          asm_keep <= word_keep;
          asm_user <= word_user;
        end
        if (s_axis_tlast) begin
          line_err <= len_bad;
          pix_cnt  <= '0;
          if (frame_end) begin
            frame_done <= 1'b1;
            line_cnt   <= '0;
            state      <= RESET_STATE;
          end else begin
            line_cnt <= line_next;
          end
        end else begin
          pix_cnt  <= pix_next;
          line_cnt <= base_line;
        end
      end
    end
  end

endmodule
